interlacer_v1: RTL and testbench

- Converts a progressive Avalon-ST video stream (control packet + video packet per frame) into an interlaced field stream.
- Each frame becomes one field: F0 (even rows 0,2,4,…) and F1 (odd rows 1,3,5,…) alternate frame by frame.
- Sits on the transmit side of the pipeline as the counterpart of the deinterlacer: progressive frames in, interlaced fields out.
- Every field is preceded by a regenerated control packet: width = WIDTH, height = HEIGHT/2, interlace nibble set.

---
 rtl/interlacer_v1.sv | 125 ++++++++++++
 tb/tb_interlacer_v1.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/interlacer_v1.sv
// interlacer_v1: turns progressive Avalon-ST frames into alternating F0/F1 interlaced fields
module interlacer_v1 #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  field_parity
);
  typedef enum logic [2:0] {IDLE, IN_CTRL, DROP, TX_CTRL, VID_HDR, PIXELS, DRAIN, FILL} state_t;

  localparam logic [15:0] W_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] W16    = 16'(WIDTH);
  localparam logic [15:0] HALF_H = 16'(HEIGHT / 2);

  state_t          state_q;
  logic [15:0]     row_q, col_q;
  logic [3:0]      ctrl_q;
  logic            parity_q;

  logic            out_free, fire, keep, col_wrap, end_field;
  logic [15:0]     last_row, nib_src;
  logic [3:0]      hdr_type, ctrl_m1, sh, nib;
  logic [7:0]      ctrl_byte;
  logic            ld, ld_sop, ld_eop;
  logic [DATA_WIDTH-1:0] ld_data;

  assign out_free  = !dout_valid || dout_ready;
  assign fire      = din_valid && din_ready;
  assign hdr_type  = din_data[3:0];
  assign keep      = row_q[0] == parity_q;
  assign col_wrap  = col_q == W_LAST;
  assign last_row  = parity_q ? 16'(HEIGHT - 1) : 16'(HEIGHT - 2);
  assign end_field = col_wrap && row_q == last_row;

  // Control packet nibbles: beats 1-4 carry WIDTH, 5-8 carry HEIGHT/2, most significant first
  assign ctrl_m1   = ctrl_q - 4'd1;
  assign sh        = 4'd12 - {ctrl_m1[1:0], 2'b00};
  assign nib_src   = ctrl_q < 4'd5 ? W16 : HALF_H;
  assign nib       = 4'(nib_src >> sh);
  assign ctrl_byte = ctrl_q == 4'd0 ? 8'h0F :
                     ctrl_q == 4'd9 ? {4'h0, 1'b1, parity_q, 2'b00} : {4'h0, nib};

  // Type-0 headers are held at the input until the regenerated control packet is out
  assign din_ready = state_q == IDLE    ? !(din_valid && din_startofpacket && hdr_type == 4'h0) :
                     state_q == TX_CTRL ? 1'b0 :
                     state_q == FILL    ? 1'b0 :
                     state_q == VID_HDR ? out_free :
                     state_q == PIXELS  ? (keep ? out_free : 1'b1) : 1'b1;

  // Output register load requests; only raised when the register is free
  assign ld      = state_q == TX_CTRL ? out_free :
                   state_q == VID_HDR ? fire :
                   state_q == PIXELS  ? fire && (keep || (din_endofpacket && out_free)) :
                   state_q == FILL && out_free;
  assign ld_data = state_q == TX_CTRL ? DATA_WIDTH'(ctrl_byte) :
                   (state_q == PIXELS && keep) ? din_data : '0;
  assign ld_sop  = state_q == TX_CTRL ? ctrl_q == 4'd0 : state_q == VID_HDR;
  assign ld_eop  = state_q == TX_CTRL ? ctrl_q == 4'd9 :
                   state_q == PIXELS  ? (keep ? end_field || din_endofpacket : 1'b1) :
                   state_q == FILL;

  assign field_parity = parity_q;

  // Packet FSM, raster counters, field parity and the one-entry output register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q            <= IDLE;
      row_q              <= '0;
      col_q              <= '0;
      ctrl_q             <= '0;
      parity_q           <= 1'b0;
      dout_valid         <= 1'b0;
      dout_data          <= '0;
      dout_startofpacket <= 1'b0;
      dout_endofpacket   <= 1'b0;
    end else begin
      if (ld) begin
        dout_valid         <= 1'b1;
        dout_data          <= ld_data;
        dout_startofpacket <= ld_sop;
        dout_endofpacket   <= ld_eop;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      case (state_q)
        IDLE: if (din_valid && din_startofpacket) begin
          state_q <= hdr_type == 4'h0 ? TX_CTRL :
                     din_endofpacket  ? IDLE :
                     hdr_type == 4'hF ? IN_CTRL : DROP;
          ctrl_q  <= '0;
        end
        IN_CTRL, DROP, DRAIN: if (fire && din_endofpacket) state_q <= IDLE;
        TX_CTRL: if (out_free) begin
          ctrl_q <= ctrl_q + 4'd1;
          if (ctrl_q == 4'd9) state_q <= VID_HDR;
        end
        VID_HDR: if (fire) begin
          row_q   <= '0;
          col_q   <= '0;
          state_q <= PIXELS;
        end
        PIXELS: if (fire) begin
          col_q <= col_wrap ? '0 : col_q + 16'd1;
          row_q <= row_q + {15'd0, col_wrap};
          if (end_field || din_endofpacket) parity_q <= ~parity_q;
          if (end_field) state_q <= din_endofpacket ? IDLE : DRAIN;
          else if (din_endofpacket) state_q <= (keep || out_free) ? IDLE : FILL;
        end
        FILL: if (out_free) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interlacer_v1.sv
// tb_interlacer_v1: randomized scoreboard bench for the progressive-to-interlaced converter
module tb_interlacer_v1;
  localparam int W = 4;
  localparam int H = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din_data = 8'h00;
  logic       din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic       din_ready;
  logic [7:0] dout_data;
  logic       dout_valid, dout_sop, dout_eop, field_parity;
  logic       dout_ready = 1'b1;

  int         n_vec = 0, n_err = 0;
  logic [9:0] q[$];
  logic       par = 1'b0;
  int         rmode = 0, ph = 0, last_wait = 0, hdr_wait = 0;
  bit         gaps = 1'b0, hold = 1'b0;
  logic [9:0] held;

  interlacer_v1 #(.DATA_WIDTH(8), .WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .din_startofpacket(din_sop), .din_endofpacket(din_eop),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop),
    .field_parity(field_parity)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // sink back-pressure: always ready, 1,0,0,1 pattern, or random
  initial forever begin
    @(posedge clock);
    #1;
    dout_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (ph % 4 == 0 || ph % 4 == 3) : 1'($urandom_range(0, 1));
    ph++;
  end

  // output monitor: scoreboard compare plus hold-stability while stalled
  initial forever begin
    @(negedge clock);
    if (!reset) hold = 1'b0;
    else begin
      if (hold) chk("stable", 32'({dout_sop, dout_eop, dout_data}), 32'(held));
      if (dout_valid && dout_ready) begin
        if (q.size() == 0) chk("extra", 32'({dout_sop, dout_eop, dout_data}), 32'hFFFF_FFFF);
        else chk("beat", 32'({dout_sop, dout_eop, dout_data}), 32'(q.pop_front()));
      end
      hold = dout_valid && !dout_ready;
      held = {dout_sop, dout_eop, dout_data};
    end
  end

  // reference: one field per video packet, expressed on (row, col) of the raster
  task automatic exp_field(input logic [7:0] px[$]);
    int  last_row = par ? H - 1 : H - 2;
    bit  fin, last;
    q.push_back({2'b10, 8'h0F});
    for (int k = 0; k < 4; k++) q.push_back({2'b00, 8'((W >> (12 - 4 * k)) & 15)});
    for (int k = 0; k < 4; k++) q.push_back({2'b00, 8'(((H / 2) >> (12 - 4 * k)) & 15)});
    q.push_back({2'b01, par ? 8'h0C : 8'h08});
    q.push_back({2'b10, 8'h00});
    for (int i = 0; i < px.size(); i++) begin
      fin  = (i / W) == last_row && (i % W) == W - 1;
      last = i == px.size() - 1;
      if ((i / W) % 2 == int'(par)) begin
        q.push_back({1'b0, fin || last, px[i]});
        if (fin || last) break;
      end else if (last) begin
        q.push_back({2'b01, 8'h00});
        break;
      end
    end
    par = ~par;
  endtask

  // the literal F0 field for the 4x4 test image
  task automatic exp_literal_f0();
    logic [9:0] lit[19] = '{10'h20F, 10'h000, 10'h000, 10'h000, 10'h004, 10'h000, 10'h000,
                            10'h000, 10'h002, 10'h108, 10'h200, 10'h000, 10'h001, 10'h002,
                            10'h003, 10'h020, 10'h021, 10'h022, 10'h123};
    foreach (lit[i]) q.push_back(lit[i]);
    par = 1'b1;
  endtask

  task automatic send(input logic [7:0] d, input bit s, input bit e);
    int k = 0;
    bit r;
    if (gaps) repeat ($urandom_range(0, 1)) begin
      din_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    din_data = d; din_sop = s; din_eop = e; din_valid = 1'b1;
    forever begin
      @(negedge clock);
      r = din_ready;
      @(posedge clock);
      #1;
      if (r) break;
      k++;
      if (k > 500) begin
        chk("in_stall", 32'(k), 32'd0);
        break;
      end
    end
    last_wait = k;
  endtask

  task automatic ctrl_pkt();
    send(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0, i == 7);
    din_valid = 1'b0;
  endtask

  task automatic video(input int n, input bit directed, input bit use_model, input int upto);
    logic [7:0] px[$];
    for (int i = 0; i < n; i++) px.push_back(directed ? 8'((i / W) * 16 + i % W) : 8'($urandom));
    if (use_model) exp_field(px);
    send(8'h00, 1'b1, 1'b0);
    hdr_wait = last_wait;
    for (int i = 0; i < upto; i++) send(px[i], 1'b0, i == n - 1);
    din_valid = 1'b0;
  endtask

  task automatic flush(input string tag);
    int k = 0;
    while ((q.size() != 0 || dout_valid) && k < 300) begin
      @(posedge clock);
      k++;
    end
    #1;
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_data", 32'(dout_data), 32'd0);
    chk("rst_sop", 32'(dout_sop), 32'd0);
    chk("rst_eop", 32'(dout_eop), 32'd0);
    chk("rst_parity", 32'(field_parity), 32'd0);
    reset = 1'b1;
    #1;
    chk("idle_ready", 32'(din_ready), 32'd1);

    exp_literal_f0();
    ctrl_pkt();
    video(16, 1'b1, 1'b0, 16);
    chk("hdr_wait1", 32'(hdr_wait), 32'd11);
    flush("flush1");
    chk("parity1", 32'(field_parity), 32'd1);

    ctrl_pkt();
    video(16, 1'b1, 1'b1, 16);
    flush("flush2");
    chk("parity2", 32'(field_parity), 32'd0);

    video(16, 1'b1, 1'b1, 16);
    chk("hdr_wait3", 32'(hdr_wait), 32'd11);
    flush("flush3");
    chk("parity3", 32'(field_parity), 32'd1);

    video(16, 1'b1, 1'b1, 10);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_parity", 32'(field_parity), 32'd0);
    reset = 1'b1;
    q.delete();
    par = 1'b0;
    exp_literal_f0();
    ctrl_pkt();
    video(16, 1'b1, 1'b0, 16);
    flush("flush_rst");
    video(16, 1'b1, 1'b1, 16);
    flush("flush_f1");
    chk("parity4", 32'(field_parity), 32'd0);

    rmode = 1;
    ctrl_pkt();
    video(16, 1'b1, 1'b1, 16);
    ctrl_pkt();
    video(16, 1'b1, 1'b1, 16);
    flush("flush_bp");
    rmode = 0;
    chk("parity_bp", 32'(field_parity), 32'd0);

    video(6, 1'b1, 1'b1, 6);
    flush("flush_early");
    chk("parity_early", 32'(field_parity), 32'd1);
    video(16, 1'b1, 1'b1, 16);
    flush("flush_after_early");
    chk("parity_after_early", 32'(field_parity), 32'd0);

    rmode = 2;
    gaps  = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int n;
      if ($urandom_range(0, 3) == 0) begin
        send(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        din_valid = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        send({4'($urandom), 4'($urandom_range(1, 14))}, 1'b1, 1'b0);
        send(8'($urandom), 1'b0, 1'b1);
        din_valid = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) ctrl_pkt();
      n = $urandom_range(0, 2) == 0 ? W * H : $urandom_range(1, W * H + 4);
      video(n, 1'b0, 1'b1, n);
      chk("parity_rand", 32'(field_parity), 32'(par));
    end
    rmode = 0;
    gaps  = 1'b0;
    flush("flush_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
